// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV64 control FSM: opcodes, branch funct3,
// state enum and datapath select enums.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OpTypeR    = 7'b0110011;
    localparam logic [6:0] OpImmArith = 7'b0010011;
    localparam logic [6:0] OpLd       = 7'b0000011;
    localparam logic [6:0] OpTypeS    = 7'b0100011;
    localparam logic [6:0] OpTypeSb   = 7'b1100011;
    localparam logic [6:0] OpTypeUj   = 7'b1101111;
    localparam logic [6:0] OpJalr     = 7'b1100111;
    localparam logic [6:0] OpTypeU    = 7'b0110111;

    localparam logic [2:0] F3Beq = 3'b000;
    localparam logic [2:0] F3Bne = 3'b001;
    localparam logic [2:0] F3Blt = 3'b100;
    localparam logic [2:0] F3Bge = 3'b101;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExecR  = 4'd2,
        StExecI  = 4'd3,
        StExecU  = 4'd4,
        StAluWb  = 4'd5,
        StAddr   = 4'd6,
        StMemRd  = 4'd7,
        StLdWb   = 4'd8,
        StMemWr  = 4'd9,
        StBranch = 4'd10,
        StJal    = 4'd11,
        StJalr   = 4'd12,
        StHalt   = 4'd13,
        StTrap   = 4'd14
    } state_e;

    typedef enum logic [1:0] {
        PcSrcAlu     = 2'd0,
        PcSrcAluOut  = 2'd1,
        PcSrcAluMask = 2'd2
    } pc_src_e;

    typedef enum logic [1:0] {
        ASelPc    = 2'd0,
        ASelRs1   = 2'd1,
        ASelZero  = 2'd2,
        ASelOldPc = 2'd3
    } a_sel_e;

    typedef enum logic [1:0] {
        BSelRs2    = 2'd0,
        BSelFour   = 2'd1,
        BSelImm    = 2'd2,
        BSelImmShl = 2'd3
    } b_sel_e;

    typedef enum logic [1:0] {
        AluAdd   = 2'd0,
        AluSub   = 2'd1,
        AluFunct = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        WbAluOut = 2'd0,
        WbMdr    = 2'd1,
        WbPc     = 2'd2
    } wb_sel_e;

    // States that hold a memory request open until i_mem_ready.
    function automatic logic is_mem_wait(input state_e st);
        return st inside {StFetch, StMemRd, StMemWr};
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-to-datapath bundle; master is the controller, slave the datapath.
// o_trap exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [31:0] i_instr;
    logic        i_mem_ready;
    logic        i_alu_zero;
    logic        i_alu_lt;

    logic        o_pc_write;
    pc_src_e     o_pc_src;
    logic        o_ir_write;
    logic        o_iord;
    logic        o_mem_read;
    logic        o_mem_write;
    a_sel_e      o_alu_a_sel;
    b_sel_e      o_alu_b_sel;
    alu_op_e     o_alu_op;
    logic        o_reg_write;
    wb_sel_e     o_wb_sel;
    logic        o_mem_err;
    state_e      o_state;
`ifdef ILLEGAL_TRAP_EN
    logic        o_trap;
`endif

    modport master (
        input  i_instr, i_mem_ready, i_alu_zero, i_alu_lt,
`ifdef ILLEGAL_TRAP_EN
        output o_trap,
`endif
        output o_pc_write, o_pc_src, o_ir_write, o_iord, o_mem_read, o_mem_write,
        output o_alu_a_sel, o_alu_b_sel, o_alu_op, o_reg_write, o_wb_sel,
        output o_mem_err, o_state
    );

    modport slave (
        output i_instr, i_mem_ready, i_alu_zero, i_alu_lt,
`ifdef ILLEGAL_TRAP_EN
        input  o_trap,
`endif
        input  o_pc_write, o_pc_src, o_ir_write, o_iord, o_mem_read, o_mem_write,
        input  o_alu_a_sel, o_alu_b_sel, o_alu_op, o_reg_write, o_wb_sel,
        input  o_mem_err, o_state
    );

endinterface

// File: rtl/multicycle_ctrl_branch_cond.sv
// Combinational branch resolver: funct3 plus ALU zero/lt flags to taken,
// with a flag for funct3 encodings this core does not implement.
module multicycle_ctrl_branch_cond
    import multicycle_ctrl_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       zero_i,
    input  logic       lt_i,
    output logic       taken_o,
    output logic       supported_o
);

    always_comb begin
        taken_o     = 1'b0;
        supported_o = 1'b1;
        case (funct3_i)
            F3Beq:   taken_o = zero_i;
            F3Bne:   taken_o = !zero_i;
            F3Blt:   taken_o = lt_i;
            F3Bge:   taken_o = !lt_i;
            default: supported_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV64 control FSM: sequences fetch/decode/execute/memory/writeback.
// Optional macro ILLEGAL_TRAP_EN turns unknown opcodes and branch funct3 into a TRAP state.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    multicycle_ctrl_if.master bus_io
);

`ifdef ILLEGAL_TRAP_EN
    localparam logic TrapEn = 1'b1;
`else
    localparam logic TrapEn = 1'b0;
`endif
    localparam logic XlenIs64 = (XLEN == 64);

    state_e      state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       mem_ready;
    logic       br_taken, br_supported;
    logic       waiting, timeout;

    assign opcode    = bus_io.i_instr[6:0];
    assign funct3    = bus_io.i_instr[14:12];
    assign mem_ready = bus_io.i_mem_ready;

    multicycle_ctrl_branch_cond u_branch_cond (
        .funct3_i    (funct3),
        .zero_i      (bus_io.i_alu_zero),
        .lt_i        (bus_io.i_alu_lt),
        .taken_o     (br_taken),
        .supported_o (br_supported)
    );

    // Counts consecutive unanswered request cycles; restarts whenever the wait ends.
    assign waiting    = is_mem_wait(state_q) && !mem_ready;
    assign wait_cnt_d = waiting ? wait_cnt_q + 32'd1 : 32'd0;
    assign timeout    = (MEM_TIMEOUT != 0) && waiting && (wait_cnt_d == MEM_TIMEOUT);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                if (timeout)        state_d = StHalt;
                else if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                case (opcode)
                    OpTypeR:          state_d = StExecR;
                    OpImmArith:       state_d = StExecI;
                    OpLd, OpTypeS:    state_d = StAddr;
                    OpTypeSb:         state_d = StBranch;
                    OpTypeUj:         state_d = StJal;
                    OpJalr:           state_d = StJalr;
                    OpTypeU:          state_d = StExecU;
                    default:          state_d = TrapEn ? StTrap : StFetch;
                endcase
            end
            StExecR, StExecI, StExecU: state_d = StAluWb;
            StAddr:   state_d = (opcode == OpLd) ? StMemRd : StMemWr;
            StMemRd: begin
                if (timeout)        state_d = StHalt;
                else if (mem_ready) state_d = StLdWb;
            end
            StMemWr: begin
                if (timeout)        state_d = StHalt;
                else if (mem_ready) state_d = StFetch;
            end
            StBranch: state_d = (TrapEn && !br_supported) ? StTrap : StFetch;
            StAluWb, StLdWb, StJal, StJalr: state_d = StFetch;
            StHalt:   state_d = StHalt;
            StTrap:   state_d = StTrap;
            default:  state_d = StFetch;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= StFetch;
            wait_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    logic    pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    pc_src_e pc_src;
    a_sel_e  a_sel;
    b_sel_e  b_sel;
    alu_op_e alu_op;
    wb_sel_e wb_sel;

    // Outputs are gated by i_rst_n so a mid-instruction reset kills every enable at once.
    always_comb begin
        pc_write  = 1'b0;
        pc_src    = PcSrcAlu;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        a_sel     = ASelPc;
        b_sel     = BSelRs2;
        alu_op    = AluAdd;
        reg_write = 1'b0;
        wb_sel    = WbAluOut;
        if (i_rst_n) begin
            unique case (state_q)
                StFetch: begin
                    mem_read = 1'b1;
                    b_sel    = BSelFour;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                StDecode: begin
                    a_sel = ASelOldPc;
                    b_sel = BSelImmShl;
                end
                StExecR: begin
                    a_sel  = ASelRs1;
                    alu_op = AluFunct;
                end
                StExecI: begin
                    a_sel  = ASelRs1;
                    b_sel  = BSelImm;
                    alu_op = AluFunct;
                end
                StExecU: begin
                    a_sel = ASelZero;
                    b_sel = BSelImm;
                end
                StAluWb: reg_write = 1'b1;
                StAddr: begin
                    a_sel = ASelRs1;
                    b_sel = BSelImm;
                end
                StMemRd: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                StLdWb: begin
                    reg_write = 1'b1;
                    wb_sel    = WbMdr;
                end
                StMemWr: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                StBranch: begin
                    a_sel  = ASelRs1;
                    alu_op = AluSub;
                    if (br_taken) begin
                        pc_write = 1'b1;
                        pc_src   = PcSrcAluOut;
                    end
                end
                StJal: begin
                    reg_write = 1'b1;
                    wb_sel    = WbPc;
                    pc_write  = 1'b1;
                    pc_src    = PcSrcAluOut;
                end
                StJalr: begin
                    a_sel     = ASelRs1;
                    b_sel     = BSelImm;
                    pc_write  = 1'b1;
                    pc_src    = PcSrcAluMask;
                    reg_write = 1'b1;
                    wb_sel    = WbPc;
                end
                default: ;
            endcase
        end
    end

    assign bus_io.o_pc_write  = pc_write;
    assign bus_io.o_pc_src    = pc_src;
    assign bus_io.o_ir_write  = ir_write;
    assign bus_io.o_iord      = iord;
    assign bus_io.o_mem_read  = mem_read;
    assign bus_io.o_mem_write = mem_write;
    assign bus_io.o_alu_a_sel = a_sel;
    assign bus_io.o_alu_b_sel = b_sel;
    assign bus_io.o_alu_op    = alu_op;
    assign bus_io.o_reg_write = reg_write;
    assign bus_io.o_wb_sel    = wb_sel;
    assign bus_io.o_mem_err   = i_rst_n && (state_q == StHalt);
    assign bus_io.o_state     = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign bus_io.o_trap      = i_rst_n && (state_q == StTrap);
`endif

    logic unused_bits;
    assign unused_bits = ^{bus_io.i_instr[31:15], bus_io.i_instr[11:7], XlenIs64};

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle expected output vectors are queued
// alongside the stimulus and compared as the FSM steps (MEM_TIMEOUT = 4).
module tb_multicycle_ctrl;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3;
    localparam logic [3:0] S_EXEC_U = 4'd4, S_ALU_WB = 4'd5, S_ADDR = 4'd6, S_MEM_RD = 4'd7;
    localparam logic [3:0] S_LD_WB = 4'd8, S_MEM_WR = 4'd9, S_BRANCH = 4'd10, S_JAL = 4'd11;
    localparam logic [3:0] S_JALR = 4'd12, S_HALT = 4'd13, S_TRAP = 4'd14;

    localparam logic [31:0] I_ADDI = 32'h00500093, I_ADD = 32'h002081B3, I_LUI = 32'h123450B7;
    localparam logic [31:0] I_LD = 32'h0080B103, I_SD = 32'h0020B023, I_BEQ = 32'h00208463;
    localparam logic [31:0] I_BNE = 32'h00209463, I_BLT = 32'h0020C463, I_BGE = 32'h0020D463;
    localparam logic [31:0] I_BBAD = 32'h0020A463, I_JAL = 32'h008000EF, I_JALR = 32'h000080E7;
    localparam logic [31:0] I_ILL = 32'h0000007F;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic [1:0] a_sel;
        logic [1:0] b_sel;
        logic [1:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       mem_err;
        logic       trap;
        logic [3:0] state;
    } outs_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        rdy;
        logic        zero;
        logic        lt;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    stim_t stim_q[$];
    outs_t exp_q[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(
        .XLEN        (64),
        .MEM_TIMEOUT (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus_io  (bus)
    );

    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t v;
        v.pc_write  = bus.o_pc_write;
        v.pc_src    = bus.o_pc_src;
        v.ir_write  = bus.o_ir_write;
        v.iord      = bus.o_iord;
        v.mem_read  = bus.o_mem_read;
        v.mem_write = bus.o_mem_write;
        v.a_sel     = bus.o_alu_a_sel;
        v.b_sel     = bus.o_alu_b_sel;
        v.alu_op    = bus.o_alu_op;
        v.reg_write = bus.o_reg_write;
        v.wb_sel    = bus.o_wb_sel;
        v.mem_err   = bus.o_mem_err;
        v.state     = bus.o_state;
`ifdef ILLEGAL_TRAP_EN
        v.trap      = bus.o_trap;
`else
        v.trap      = 1'b0;
`endif
        return v;
    endfunction

    function automatic outs_t v_st(input logic [3:0] st);
        outs_t v = '0;
        v.state = st;
        return v;
    endfunction

    function automatic outs_t v_fetch(input logic rdy);
        outs_t v = v_st(S_FETCH);
        v.mem_read = 1'b1;
        v.b_sel    = 2'd1;
        v.ir_write = rdy;
        v.pc_write = rdy;
        return v;
    endfunction

    function automatic outs_t v_alu(input logic [3:0] st, input logic [1:0] a, b, op);
        outs_t v = v_st(st);
        v.a_sel  = a;
        v.b_sel  = b;
        v.alu_op = op;
        return v;
    endfunction

    function automatic outs_t v_wb(input logic [3:0] st, input logic [1:0] sel);
        outs_t v = v_st(st);
        v.reg_write = 1'b1;
        v.wb_sel    = sel;
        return v;
    endfunction

    function automatic outs_t v_mem(input logic [3:0] st, input logic rd, input logic wr);
        outs_t v = v_st(st);
        v.iord      = 1'b1;
        v.mem_read  = rd;
        v.mem_write = wr;
        return v;
    endfunction

    function automatic outs_t v_branch(input logic taken);
        outs_t v = v_alu(S_BRANCH, 2'd1, 2'd0, 2'd1);
        v.pc_write = taken;
        v.pc_src   = taken ? 2'd1 : 2'd0;
        return v;
    endfunction

    function automatic outs_t v_jump(input logic is_jalr);
        outs_t v = is_jalr ? v_alu(S_JALR, 2'd1, 2'd2, 2'd0) : v_st(S_JAL);
        v.pc_write  = 1'b1;
        v.pc_src    = is_jalr ? 2'd2 : 2'd1;
        v.reg_write = 1'b1;
        v.wb_sel    = 2'd2;
        return v;
    endfunction

    task automatic push(input logic [31:0] instr, input logic rdy, zero, lt, input outs_t e);
        stim_t s;
        s.instr = instr;
        s.rdy   = rdy;
        s.zero  = zero;
        s.lt    = lt;
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_mem_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        outs_t act;
        bus.i_instr = I_ADDI;
        bus.i_mem_ready = 1'b1;
        bus.i_alu_zero = 1'b0;
        bus.i_alu_lt = 1'b0;
        #3;
        act = sample();
        checks++;
        if (act !== v_st(S_FETCH)) begin
            errors++;
            $display("FAIL reset_hold got %h want %h", act, v_st(S_FETCH));
        end
        @(posedge clk);
        #1;
        act = sample();
        checks++;
        if (act !== v_st(S_FETCH)) begin
            errors++;
            $display("FAIL reset_edge got %h want %h", act, v_st(S_FETCH));
        end
        @(negedge clk);
        bus.i_mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        act = sample();
        checks++;
        if (act !== v_fetch(1'b0)) begin
            errors++;
            $display("FAIL reset_release got %h want %h", act, v_fetch(1'b0));
        end
    endtask

    task automatic test_alu();
        stim_t s;
        outs_t e, act;
        int n = 0;
        push(I_ADDI, 1, 0, 0, v_fetch(1));
        push(I_ADDI, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
        push(I_ADDI, 0, 0, 0, v_alu(S_EXEC_I, 2'd1, 2'd2, 2'd2));
        push(I_ADDI, 0, 0, 0, v_wb(S_ALU_WB, 2'd0));
        push(I_ADD, 1, 0, 0, v_fetch(1));
        push(I_ADD, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
        push(I_ADD, 0, 0, 0, v_alu(S_EXEC_R, 2'd1, 2'd0, 2'd2));
        push(I_ADD, 0, 0, 0, v_wb(S_ALU_WB, 2'd0));
        push(I_LUI, 1, 0, 0, v_fetch(1));
        push(I_LUI, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
        push(I_LUI, 0, 0, 0, v_alu(S_EXEC_U, 2'd2, 2'd2, 2'd0));
        push(I_LUI, 0, 0, 0, v_wb(S_ALU_WB, 2'd0));
        while (exp_q.size() != 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            bus.i_instr = s.instr; bus.i_mem_ready = s.rdy;
            bus.i_alu_zero = s.zero; bus.i_alu_lt = s.lt;
            #1;
            e = exp_q.pop_front();
            act = sample();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL alu cyc %0d got %h want %h", n, act, e);
            end
            n++;
        end
    endtask

    task automatic test_load();
        stim_t s;
        outs_t e, act;
        int n = 0;
        push(I_LD, 1, 0, 0, v_fetch(1));
        push(I_LD, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
        push(I_LD, 0, 0, 0, v_alu(S_ADDR, 2'd1, 2'd2, 2'd0));
        for (int i = 0; i < 3; i++) push(I_LD, 0, 0, 0, v_mem(S_MEM_RD, 1, 0));
        push(I_LD, 1, 0, 0, v_mem(S_MEM_RD, 1, 0));
        push(I_LD, 0, 0, 0, v_wb(S_LD_WB, 2'd1));
        while (exp_q.size() != 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            bus.i_instr = s.instr; bus.i_mem_ready = s.rdy;
            bus.i_alu_zero = s.zero; bus.i_alu_lt = s.lt;
            #1;
            e = exp_q.pop_front();
            act = sample();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL load cyc %0d got %h want %h", n, act, e);
            end
            n++;
        end
    endtask

    task automatic test_store();
        stim_t s;
        outs_t e, act;
        int n = 0;
        push(I_SD, 1, 0, 0, v_fetch(1));
        push(I_SD, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
        push(I_SD, 0, 0, 0, v_alu(S_ADDR, 2'd1, 2'd2, 2'd0));
        push(I_SD, 1, 0, 0, v_mem(S_MEM_WR, 0, 1));
        push(I_SD, 1, 0, 0, v_fetch(1));
        push(I_SD, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
        push(I_SD, 0, 0, 0, v_alu(S_ADDR, 2'd1, 2'd2, 2'd0));
        push(I_SD, 0, 0, 0, v_mem(S_MEM_WR, 0, 1));
        push(I_SD, 1, 0, 0, v_mem(S_MEM_WR, 0, 1));
        while (exp_q.size() != 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            bus.i_instr = s.instr; bus.i_mem_ready = s.rdy;
            bus.i_alu_zero = s.zero; bus.i_alu_lt = s.lt;
            #1;
            e = exp_q.pop_front();
            act = sample();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL store cyc %0d got %h want %h", n, act, e);
            end
            n++;
        end
    endtask

    task automatic test_branch();
        stim_t s;
        outs_t e, act;
        int n = 0;
        logic [31:0] ins[6] = '{I_BEQ, I_BEQ, I_BNE, I_BLT, I_BGE, I_BGE};
        logic        zf[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic        lf[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        tk[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            push(ins[i], 1, 0, 0, v_fetch(1));
            push(ins[i], 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
            push(ins[i], 0, zf[i], lf[i], v_branch(tk[i]));
        end
        while (exp_q.size() != 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            bus.i_instr = s.instr; bus.i_mem_ready = s.rdy;
            bus.i_alu_zero = s.zero; bus.i_alu_lt = s.lt;
            #1;
            e = exp_q.pop_front();
            act = sample();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL branch cyc %0d got %h want %h", n, act, e);
            end
            n++;
        end
    endtask

    task automatic test_jumps();
        stim_t s;
        outs_t e, act;
        int n = 0;
        push(I_JAL, 1, 0, 0, v_fetch(1));
        push(I_JAL, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
        push(I_JAL, 0, 0, 0, v_jump(1'b0));
        push(I_JALR, 1, 0, 0, v_fetch(1));
        push(I_JALR, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
        push(I_JALR, 0, 0, 0, v_jump(1'b1));
        while (exp_q.size() != 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            bus.i_instr = s.instr; bus.i_mem_ready = s.rdy;
            bus.i_alu_zero = s.zero; bus.i_alu_lt = s.lt;
            #1;
            e = exp_q.pop_front();
            act = sample();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL jump cyc %0d got %h want %h", n, act, e);
            end
            n++;
        end
    endtask

    task automatic test_reset_mid_write();
        stim_t s;
        outs_t e, act;
        int n = 0;
        push(I_SD, 1, 0, 0, v_fetch(1));
        push(I_SD, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
        push(I_SD, 0, 0, 0, v_alu(S_ADDR, 2'd1, 2'd2, 2'd0));
        push(I_SD, 0, 0, 0, v_mem(S_MEM_WR, 0, 1));
        while (exp_q.size() != 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            bus.i_instr = s.instr; bus.i_mem_ready = s.rdy;
            bus.i_alu_zero = s.zero; bus.i_alu_lt = s.lt;
            #1;
            e = exp_q.pop_front();
            act = sample();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL rst_wr cyc %0d got %h want %h", n, act, e);
            end
            n++;
        end
        #2 rst_n = 1'b0;
        #1;
        act = sample();
        checks++;
        if (act !== v_st(S_FETCH)) begin
            errors++;
            $display("FAIL rst_wr_async got %h want %h", act, v_st(S_FETCH));
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        act = sample();
        checks++;
        if (act !== v_fetch(1'b0)) begin
            errors++;
            $display("FAIL rst_wr_release got %h want %h", act, v_fetch(1'b0));
        end
    endtask

    task automatic test_illegal();
        stim_t s;
        outs_t e, act, t;
        int n = 0;
        t = v_st(S_TRAP);
        t.trap = 1'b1;
        push(I_ILL, 1, 0, 0, v_fetch(1));
        push(I_ILL, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
`ifdef ILLEGAL_TRAP_EN
        push(I_ILL, 1, 0, 0, t);
        push(I_ILL, 1, 0, 0, t);
`endif
        push(I_BBAD, 1, 0, 0, v_fetch(1));
        push(I_BBAD, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
        push(I_BBAD, 0, 1, 1, v_branch(1'b0));
`ifdef ILLEGAL_TRAP_EN
        push(I_BBAD, 1, 0, 0, t);
        push(I_BBAD, 1, 0, 0, t);
`endif
        while (exp_q.size() != 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            bus.i_instr = s.instr; bus.i_mem_ready = s.rdy;
            bus.i_alu_zero = s.zero; bus.i_alu_lt = s.lt;
            #1;
            e = exp_q.pop_front();
            act = sample();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL illegal cyc %0d got %h want %h", n, act, e);
            end
            n++;
`ifdef ILLEGAL_TRAP_EN
            // A trap is only left through reset; reset once the second trap cycle is checked.
            if (e.trap && (exp_q.size() == 0 || !exp_q[0].trap)) begin
                pulse_reset();
                #1;
                act = sample();
                checks++;
                if (act !== v_fetch(1'b0)) begin
                    errors++;
                    $display("FAIL trap_reset got %h want %h", act, v_fetch(1'b0));
                end
            end
`endif
        end
    endtask

    task automatic test_timeout();
        stim_t s;
        outs_t e, act, h;
        int n = 0;
        h = v_st(S_HALT);
        h.mem_err = 1'b1;
        push(I_JAL, 1, 0, 0, v_fetch(1));
        push(I_JAL, 0, 0, 0, v_alu(S_DECODE, 2'd3, 2'd3, 2'd0));
        push(I_JAL, 0, 0, 0, v_jump(1'b0));
        for (int i = 0; i < 4; i++) push(I_ADDI, 0, 0, 0, v_fetch(0));
        for (int i = 0; i < 3; i++) push(I_ADDI, 1, 0, 0, h);
        while (exp_q.size() != 0) begin
            @(negedge clk);
            s = stim_q.pop_front();
            bus.i_instr = s.instr; bus.i_mem_ready = s.rdy;
            bus.i_alu_zero = s.zero; bus.i_alu_lt = s.lt;
            #1;
            e = exp_q.pop_front();
            act = sample();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL timeout cyc %0d got %h want %h", n, act, e);
            end
            n++;
        end
        pulse_reset();
        #1;
        act = sample();
        checks++;
        if (act !== v_fetch(1'b0)) begin
            errors++;
            $display("FAIL halt_reset got %h want %h", act, v_fetch(1'b0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_jumps();
        test_reset_mid_write();
        test_illegal();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
